// File: rtl/button_debounce.sv
// rtl/button_debounce.sv - per-lane push-button synchronizer, debouncer and press/release edge detector
// Optional long-press pulse output btn_l enabled by defining DEBOUNCE_LONG_EN.
module button_debounce #(
    parameter int BTN = 2,
    parameter int DBN = 1024,
    parameter int LPN = 4096
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [BTN-1:0] btn_i,
    output logic [BTN-1:0] btn_o,
    output logic [BTN-1:0] btn_p,
    output logic [BTN-1:0] btn_r
`ifdef DEBOUNCE_LONG_EN
    ,
    output logic [BTN-1:0] btn_l
`endif
);

    localparam int DBL = $clog2(DBN + 1);

    typedef enum logic [1:0] {
        IDLE_LO = 2'd0,
        WAIT_HI = 2'd1,
        IDLE_HI = 2'd2,
        WAIT_LO = 2'd3
    } state_t;

    if (DBN < 1) begin : g_bad_dbn
        $error("button_debounce: DBN must be >= 1");
    end
    if (LPN <= DBN) begin : g_bad_lpn
        $error("button_debounce: LPN must be > DBN");
    end

    for (genvar i = 0; i < BTN; i++) begin : g_lane
        logic           s1;
        logic           s;
        state_t         state;
        state_t         state_nxt;
        logic [DBL-1:0] cnt;
        logic [DBL-1:0] cnt_nxt;
        logic           o_q;
        logic           o_nxt;
        logic           p_q;
        logic           r_q;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                s1 <= 1'b0;
                s  <= 1'b0;
            end else begin
                s1 <= btn_i[i];
                s  <= s1;
            end
        end

        // The sample that moves a lane out of IDLE already counts as the first
        // stable cycle, so the level is accepted on the DBN-th stable sample.
        always_comb begin
            state_nxt = state;
            cnt_nxt   = cnt;
            case (state)
                IDLE_LO: begin
                    cnt_nxt = '0;
                    if (s) begin
                        if (DBN == 1) begin
                            state_nxt = IDLE_HI;
                        end else begin
                            state_nxt = WAIT_HI;
                            cnt_nxt   = DBL'(1);
                        end
                    end
                end
                WAIT_HI: begin
                    if (!s) begin
                        state_nxt = IDLE_LO;
                        cnt_nxt   = '0;
                    end else if (cnt == DBL'(DBN - 1)) begin
                        state_nxt = IDLE_HI;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt + DBL'(1);
                    end
                end
                IDLE_HI: begin
                    cnt_nxt = '0;
                    if (!s) begin
                        if (DBN == 1) begin
                            state_nxt = IDLE_LO;
                        end else begin
                            state_nxt = WAIT_LO;
                            cnt_nxt   = DBL'(1);
                        end
                    end
                end
                WAIT_LO: begin
                    if (s) begin
                        state_nxt = IDLE_HI;
                        cnt_nxt   = '0;
                    end else if (cnt == DBL'(DBN - 1)) begin
                        state_nxt = IDLE_LO;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt + DBL'(1);
                    end
                end
                default: begin
                    state_nxt = IDLE_LO;
                    cnt_nxt   = '0;
                end
            endcase
            o_nxt = (state_nxt == IDLE_HI) || (state_nxt == WAIT_LO);
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                state <= IDLE_LO;
                cnt   <= '0;
                o_q   <= 1'b0;
                p_q   <= 1'b0;
                r_q   <= 1'b0;
            end else begin
                state <= state_nxt;
                cnt   <= cnt_nxt;
                o_q   <= o_nxt;
                p_q   <= o_nxt & ~o_q;
                r_q   <= ~o_nxt & o_q;
            end
        end

        assign btn_o[i] = o_q;
        assign btn_p[i] = p_q;
        assign btn_r[i] = r_q;

`ifdef DEBOUNCE_LONG_EN
        localparam int HLW = $clog2(LPN + 1);
        logic [HLW-1:0] hold;
        logic [HLW-1:0] hold_nxt;
        logic           l_q;

        // Saturates at LPN so the long-press pulse fires once per hold.
        always_comb begin
            hold_nxt = '0;
            if (o_q) begin
                hold_nxt = (hold == HLW'(LPN)) ? hold : hold + HLW'(1);
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                hold <= '0;
                l_q  <= 1'b0;
            end else begin
                hold <= hold_nxt;
                l_q  <= (hold_nxt == HLW'(LPN)) && (hold != HLW'(LPN));
            end
        end

        assign btn_l[i] = l_q;
`endif
    end

endmodule

// File: tb/tb_button_debounce.sv
// tb/tb_button_debounce.sv - directed self-checking bench for button_debounce (BTN=2, DBN=4, LPN=10)
module tb_button_debounce;

    logic       clk;
    logic       rst_n;
    logic [1:0] btn_i;
    logic [1:0] btn_o;
    logic [1:0] btn_p;
    logic [1:0] btn_r;
`ifdef DEBOUNCE_LONG_EN
    logic [1:0] btn_l;
`endif

    int vec;
    int err;

    button_debounce #(
        .BTN(2),
        .DBN(4),
        .LPN(10)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .btn_i(btn_i),
        .btn_o(btn_o),
        .btn_p(btn_p),
        .btn_r(btn_r)
`ifdef DEBOUNCE_LONG_EN
        ,
        .btn_l(btn_l)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        rst_n = 1'b0;
        btn_i = 2'b00;
        repeat (3) @(negedge clk);
        vec++;
        if ({btn_o, btn_p, btn_r} !== 6'b0) begin
            err++;
            $display("FAIL reset_hold got=%b want=000000", {btn_o, btn_p, btn_r});
        end
        rst_n = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            vec++;
            if ({btn_o, btn_p, btn_r} !== 6'b0) begin
                err++;
                $display("FAIL reset_idle cyc=%0d got=%b want=000000", k, {btn_o, btn_p, btn_r});
            end
        end
    endtask

    task automatic test_press();
        logic [1:0] eo, ep;
        btn_i = 2'b01;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            eo = (k >= 6) ? 2'b01 : 2'b00;
            ep = (k == 6) ? 2'b01 : 2'b00;
            vec++;
            if (btn_o !== eo) begin
                err++;
                $display("FAIL press_o cyc=%0d got=%b want=%b", k, btn_o, eo);
            end
            vec++;
            if (btn_p !== ep) begin
                err++;
                $display("FAIL press_p cyc=%0d got=%b want=%b", k, btn_p, ep);
            end
            vec++;
            if (btn_r !== 2'b00) begin
                err++;
                $display("FAIL press_r cyc=%0d got=%b want=00", k, btn_r);
            end
        end
    endtask

    task automatic test_release();
        logic [1:0] eo, er;
        btn_i = 2'b00;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            eo = (k >= 6) ? 2'b00 : 2'b01;
            er = (k == 6) ? 2'b01 : 2'b00;
            vec++;
            if (btn_o !== eo) begin
                err++;
                $display("FAIL release_o cyc=%0d got=%b want=%b", k, btn_o, eo);
            end
            vec++;
            if (btn_r !== er) begin
                err++;
                $display("FAIL release_r cyc=%0d got=%b want=%b", k, btn_r, er);
            end
            vec++;
            if (btn_p !== 2'b00) begin
                err++;
                $display("FAIL release_p cyc=%0d got=%b want=00", k, btn_p);
            end
        end
    endtask

    task automatic test_bounce();
        logic [9:0] pat;
        logic [1:0] eo, ep;
        pat = 10'b1111101101;
        btn_i = {1'b0, pat[0]};
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            eo = (k >= 11) ? 2'b01 : 2'b00;
            ep = (k == 11) ? 2'b01 : 2'b00;
            vec++;
            if (btn_o !== eo) begin
                err++;
                $display("FAIL bounce_o cyc=%0d got=%b want=%b", k, btn_o, eo);
            end
            vec++;
            if (btn_p !== ep) begin
                err++;
                $display("FAIL bounce_p cyc=%0d got=%b want=%b", k, btn_p, ep);
            end
            btn_i = {1'b0, (k < 10) ? pat[k] : 1'b1};
        end
    endtask

    task automatic test_glitch();
        btn_i = 2'b11;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (k == 3) btn_i = 2'b01;
            vec++;
            if ({btn_o, btn_p, btn_r} !== 6'b010000) begin
                err++;
                $display("FAIL glitch cyc=%0d got=%b want=010000", k, {btn_o, btn_p, btn_r});
            end
        end
    endtask

    task automatic test_simultaneous();
        logic [1:0] eo, ep;
        btn_i = 2'b00;
        repeat (10) @(negedge clk);
        vec++;
        if (btn_o !== 2'b00) begin
            err++;
            $display("FAIL simul_idle got=%b want=00", btn_o);
        end
        btn_i = 2'b11;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            eo = (k >= 6) ? 2'b11 : 2'b00;
            ep = (k == 6) ? 2'b11 : 2'b00;
            vec++;
            if ({btn_o, btn_p} !== {eo, ep}) begin
                err++;
                $display("FAIL simul cyc=%0d got=%b want=%b", k, {btn_o, btn_p}, {eo, ep});
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [1:0] eo, ep;
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        vec++;
        if ({btn_o, btn_p, btn_r} !== 6'b0) begin
            err++;
            $display("FAIL reset_async got=%b want=000000", {btn_o, btn_p, btn_r});
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            eo = (k >= 6) ? 2'b11 : 2'b00;
            ep = (k == 6) ? 2'b11 : 2'b00;
            vec++;
            if ({btn_o, btn_p, btn_r} !== {eo, ep, 2'b00}) begin
                err++;
                $display("FAIL reset_rel cyc=%0d got=%b want=%b", k, {btn_o, btn_p, btn_r}, {eo, ep, 2'b00});
            end
        end
    endtask

`ifdef DEBOUNCE_LONG_EN
    task automatic test_long();
        logic [1:0] el;
        btn_i = 2'b00;
        repeat (10) @(negedge clk);
        for (int pass = 0; pass < 2; pass++) begin
            btn_i = 2'b01;
            for (int k = 1; k <= 30; k++) begin
                @(negedge clk);
                el = (k == 16) ? 2'b01 : 2'b00;
                vec++;
                if (btn_l !== el) begin
                    err++;
                    $display("FAIL long_l pass=%0d cyc=%0d got=%b want=%b", pass, k, btn_l, el);
                end
            end
            btn_i = 2'b00;
            for (int k = 1; k <= 10; k++) begin
                @(negedge clk);
                vec++;
                if (btn_l !== 2'b00) begin
                    err++;
                    $display("FAIL long_rel pass=%0d cyc=%0d got=%b want=00", pass, k, btn_l);
                end
            end
        end
    endtask
`endif

    initial begin
        vec   = 0;
        err   = 0;
        rst_n = 1'b0;
        btn_i = 2'b00;
        test_reset();
        test_press();
        test_release();
        test_bounce();
        test_glitch();
        test_simultaneous();
        test_reset_mid();
`ifdef DEBOUNCE_LONG_EN
        test_long();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vec, err);
        $finish;
    end

endmodule
